bank_timing_gate: RTL

Per-rank DRAM command legality gate that sits directly upstream of the rank FSM's timing counters. It tracks per-bank open/closed state plus per-bank and rank-wide timing windows (tRCD, tRP, tRAS, tWR, tCCD, tRFC) and, each cycle, reports whether the command currently offered by the scheduler may issue. An issued command reloads the relevant windows exactly as the rank FSM's load timers do, so the scheduler never presents a command that would violate a timing counter.

---
 rtl/bank_timing_gate.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bank_timing_gate.sv
// Per-rank DRAM command legality gate: tracks bank open/closed state and the
// tRCD/tRP/tRAS/tWR/tCCD/tRFC windows, and flags whether the offered command may issue.
module bank_timing_gate #(
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = 2,
  parameter int T_RCD     = 4,
  parameter int T_RP      = 4,
  parameter int T_RAS     = 10,
  parameter int T_WR      = 6,
  parameter int T_CCD     = 2,
  parameter int T_RFC     = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd_type,
  input  logic [BANK_W-1:0]    cmd_bank,
  output logic                 cmd_ready,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic                 refresh_busy
);

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_e;

  // Counters load T-1 so a window set at edge t reads zero in cycle t+T.
  localparam logic [5:0] RCD_LD = 6'(T_RCD - 1);
  localparam logic [5:0] RP_LD  = 6'(T_RP  - 1);
  localparam logic [5:0] RAS_LD = 6'(T_RAS - 1);
  localparam logic [5:0] WR_LD  = 6'(T_WR  - 1);
  localparam logic [5:0] CCD_LD = 6'(T_CCD - 1);
  localparam logic [5:0] RFC_LD = 6'(T_RFC - 1);

  function automatic logic [5:0] dec_sat(input logic [5:0] v);
    return (v == 6'd0) ? 6'd0 : v - 6'd1;
  endfunction

  logic [5:0] rcd_q [NUM_BANKS];
  logic [5:0] rcd_d [NUM_BANKS];
  logic [5:0] rp_q  [NUM_BANKS];
  logic [5:0] rp_d  [NUM_BANKS];
  logic [5:0] ras_q [NUM_BANKS];
  logic [5:0] ras_d [NUM_BANKS];
  logic [5:0] wr_q  [NUM_BANKS];
  logic [5:0] wr_d  [NUM_BANKS];
  logic [5:0] ccd_q, ccd_d;
  logic [5:0] rfc_q, rfc_d;
  logic [NUM_BANKS-1:0] bank_open_q, bank_open_d;
  logic       refresh_busy_q, refresh_busy_d;

  logic       all_rp_zero;
  logic       ready_raw;
  logic       issue;

  always_comb begin
    all_rp_zero = 1'b1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rp_q[b] != 6'd0) all_rp_zero = 1'b0;
    end
  end

  // Legality is purely combinational from the offered command and registered state.
  always_comb begin
    ready_raw = 1'b0;
    case (cmd_type)
      CMD_ACT: ready_raw = !bank_open_q[cmd_bank] && (rp_q[cmd_bank] == 6'd0);
      CMD_RD,
      CMD_WR:  ready_raw = bank_open_q[cmd_bank] && (rcd_q[cmd_bank] == 6'd0) &&
                           (ccd_q == 6'd0);
      CMD_PRE: ready_raw = bank_open_q[cmd_bank] && (ras_q[cmd_bank] == 6'd0) &&
                           (wr_q[cmd_bank] == 6'd0);
      CMD_REF: ready_raw = (bank_open_q == '0) && all_rp_zero;
      default: ready_raw = 1'b0;
    endcase
  end

  assign cmd_ready = ready_raw && !refresh_busy_q;
  assign issue     = cmd_valid && cmd_ready;

  always_comb begin
    bank_open_d = bank_open_q;
    for (int b = 0; b < NUM_BANKS; b++) begin
      rcd_d[b] = dec_sat(rcd_q[b]);
      rp_d[b]  = dec_sat(rp_q[b]);
      ras_d[b] = dec_sat(ras_q[b]);
      wr_d[b]  = dec_sat(wr_q[b]);
      if (issue && (cmd_bank == BANK_W'(b))) begin
        case (cmd_type)
          CMD_ACT: begin
            bank_open_d[b] = 1'b1;
            rcd_d[b]       = RCD_LD;
            ras_d[b]       = RAS_LD;
          end
          CMD_WR:  wr_d[b] = WR_LD;
          CMD_PRE: begin
            bank_open_d[b] = 1'b0;
            rp_d[b]        = RP_LD;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    ccd_d = dec_sat(ccd_q);
    rfc_d = dec_sat(rfc_q);
    if (issue && ((cmd_type == CMD_RD) || (cmd_type == CMD_WR))) ccd_d = CCD_LD;
    if (issue && (cmd_type == CMD_REF)) rfc_d = RFC_LD;
    refresh_busy_d = (rfc_d != 6'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        rcd_q[b] <= 6'd0;
        rp_q[b]  <= 6'd0;
        ras_q[b] <= 6'd0;
        wr_q[b]  <= 6'd0;
      end
      ccd_q          <= 6'd0;
      rfc_q          <= 6'd0;
      bank_open_q    <= '0;
      refresh_busy_q <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        rcd_q[b] <= rcd_d[b];
        rp_q[b]  <= rp_d[b];
        ras_q[b] <= ras_d[b];
        wr_q[b]  <= wr_d[b];
      end
      ccd_q          <= ccd_d;
      rfc_q          <= rfc_d;
      bank_open_q    <= bank_open_d;
      refresh_busy_q <= refresh_busy_d;
    end
  end

  assign bank_open    = bank_open_q;
  assign refresh_busy = refresh_busy_q;

endmodule
